// File: rtl/slot_reel_engine.sv
// N-reel slot machine core: free-running digit reels stopped one per
// button press, followed by a score/jackpot report phase.
module slot_reel_engine #(
    parameter int NUM_REELS   = 3,
    parameter int DIGIT_MAX   = 9,
    parameter int BASE_PERIOD = 50000000,
    parameter int PERIOD_STEP = 7000000,
    parameter int LUCKY       = 7,
    parameter int CNT_W       = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   btn,
    output logic [4*NUM_REELS-1:0] digits,
    output logic [NUM_REELS-1:0]   blank,
    output logic [1:0]             state,
    output logic [3:0]             score,
    output logic                   jackpot
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SPIN   = 2'd1,
        REPORT = 2'd2,
        BAD    = 2'd3
    } state_e;

    state_e                 st_q, st_d;
    logic                   btn_q;
    logic                   press;
    logic [3:0]             s_q, s_d;
    logic [NUM_REELS-1:0]   run_q, run_d;
    logic [CNT_W-1:0]       cnt_q [NUM_REELS];
    logic [CNT_W-1:0]       cnt_d [NUM_REELS];
    logic [3:0]             dig_q [NUM_REELS];
    logic [3:0]             dig_d [NUM_REELS];
    logic [3:0]             score_q, score_d;
    logic                   jack_q, jack_d;
    logic [4*NUM_REELS-1:0] disp_q, disp_d;
    logic [NUM_REELS-1:0]   blank_q, blank_d;
    logic [3:0]             lucky_n;
    logic                   all_eq;

    assign press = btn & ~btn_q;

    // Score and jackpot candidates from the current (frozen) reel digits
    always_comb begin
        lucky_n = '0;
        all_eq  = 1'b1;
        for (int i = 0; i < NUM_REELS; i++) begin
            if (dig_q[i] == 4'(LUCKY)) lucky_n = lucky_n + 4'd1;
            if (dig_q[i] != dig_q[0]) all_eq = 1'b0;
        end
    end

    // Game sequencing, reel prescalers and registered display image
    always_comb begin
        st_d    = st_q;
        s_d     = s_q;
        run_d   = run_q;
        score_d = score_q;
        jack_d  = jack_q;
        for (int i = 0; i < NUM_REELS; i++) begin
            cnt_d[i] = cnt_q[i];
            dig_d[i] = dig_q[i];
        end
        unique case (st_q)
            IDLE: begin
                if (press) begin
                    st_d    = SPIN;
                    s_d     = '0;
                    run_d   = '1;
                    score_d = '0;
                    jack_d  = 1'b0;
                    for (int i = 0; i < NUM_REELS; i++) begin
                        cnt_d[i] = '0;
                        dig_d[i] = '0;
                    end
                end
            end
            SPIN: begin
                for (int i = 0; i < NUM_REELS; i++) begin
                    // A reel stopped on its wrap tick keeps the old digit
                    if (press && s_q == 4'(i)) begin
                        run_d[i] = 1'b0;
                    end else if (run_q[i]) begin
                        if (cnt_q[i] == CNT_W'(BASE_PERIOD + i * PERIOD_STEP - 1)) begin
                            cnt_d[i] = '0;
                            dig_d[i] = (dig_q[i] == 4'(DIGIT_MAX)) ? 4'd0 : dig_q[i] + 4'd1;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CNT_W'(1);
                        end
                    end
                end
                if (press) begin
                    s_d = s_q + 4'd1;
                    if (s_q == 4'(NUM_REELS - 1)) begin
                        st_d    = REPORT;
                        score_d = lucky_n;
                        jack_d  = all_eq;
                    end
                end
            end
            REPORT: begin
                if (press) begin
                    st_d = IDLE;
                    for (int i = 0; i < NUM_REELS; i++) begin
                        cnt_d[i] = '0;
                        dig_d[i] = '0;
                    end
                end
            end
            default: begin
                st_d = IDLE;
                for (int i = 0; i < NUM_REELS; i++) begin
                    cnt_d[i] = '0;
                    dig_d[i] = '0;
                end
            end
        endcase

        disp_d  = '0;
        blank_d = '0;
        if (st_d == SPIN) begin
            for (int i = 0; i < NUM_REELS; i++) disp_d[4*i +: 4] = dig_d[i];
        end else if (st_d == REPORT) begin
            disp_d[3:0] = score_d;
            blank_d     = '1;
            blank_d[0]  = 1'b0;
        end
    end

    // State, reel and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q    <= IDLE;
            btn_q   <= 1'b1;
            s_q     <= '0;
            run_q   <= '0;
            score_q <= '0;
            jack_q  <= 1'b0;
            disp_q  <= '0;
            blank_q <= '0;
            for (int i = 0; i < NUM_REELS; i++) begin
                cnt_q[i] <= '0;
                dig_q[i] <= '0;
            end
        end else begin
            st_q    <= st_d;
            btn_q   <= btn;
            s_q     <= s_d;
            run_q   <= run_d;
            score_q <= score_d;
            jack_q  <= jack_d;
            disp_q  <= disp_d;
            blank_q <= blank_d;
            for (int i = 0; i < NUM_REELS; i++) begin
                cnt_q[i] <= cnt_d[i];
                dig_q[i] <= dig_d[i];
            end
        end
    end

    assign digits  = disp_q;
    assign blank   = blank_q;
    assign state   = st_q;
    assign score   = score_q;
    assign jackpot = jack_q;

endmodule

// File: tb/tb_slot_reel_engine.sv
// Directed bench for slot_reel_engine (3 reels, periods 4/6/8) with an
// expectation queue filled at stimulus time and drained after each edge.
module tb_slot_reel_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        btn;
    logic [11:0] digits;
    logic [2:0]  blank;
    logic [1:0]  state;
    logic [3:0]  score;
    logic        jackpot;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [15:0] v;
    } exp_t;

    exp_t q[$];

    slot_reel_engine #(
        .NUM_REELS(3),
        .DIGIT_MAX(9),
        .BASE_PERIOD(4),
        .PERIOD_STEP(2),
        .LUCKY(7),
        .CNT_W(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn(btn),
        .digits(digits),
        .blank(blank),
        .state(state),
        .score(score),
        .jackpot(jackpot)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [15:0] v);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        q.push_back(e);
    endtask

    task automatic pop(input logic [15:0] obs);
        exp_t e;
        if (q.size() == 0) begin
            errors++;
            $error("FAIL sb_empty observed %0h required an expectation", obs);
        end else begin
            e = q.pop_front();
            checks++;
            assert (obs === e.v) else begin
                errors++;
                $error("FAIL %s observed %0h expected %0h", e.tag, obs, e.v);
            end
        end
    endtask

    task automatic push_idle(input logic [3:0] sc, input logic jk);
        push("idle_state", 16'd0);
        push("idle_digits", 16'd0);
        push("idle_blank", 16'd0);
        push("idle_score", 16'(sc));
        push("idle_jackpot", 16'(jk));
    endtask

    task automatic pop_all();
        pop(16'(state));
        pop(16'(digits));
        pop(16'(blank));
        pop(16'(score));
        pop(16'(jackpot));
    endtask

    // Rising edge on btn; SPIN must be visible right after that edge
    task automatic enter_spin();
        btn = 1'b0;
        tick();
        btn = 1'b1;
        push("spin_state", 16'd1);
        push("spin_digits0", 16'd0);
        push("spin_blank", 16'd0);
        push("spin_score_clr", 16'd0);
        push("spin_jackpot_clr", 16'd0);
        tick();
        pop_all();
    endtask

    // Runs a game from SPIN entry; press k lands on the edge after ck edges
    task automatic play(input int c0, input int c1, input int c2,
                        output logic [3:0] sc, output logic jk);
        int          cs[3];
        int          n[3];
        bit          run[3];
        int          s;
        int          g;
        logic [11:0] ed;
        cs  = '{c0, c1, c2};
        n   = '{0, 0, 0};
        run = '{1'b1, 1'b1, 1'b1};
        s   = 0;
        g   = 0;
        sc  = '0;
        jk  = 1'b0;
        while (s < 3 && g < 400) begin
            btn = (g == cs[s]);
            for (int i = 0; i < 3; i++)
                if (run[i] && !(btn && i == s)) n[i]++;
            if (btn) begin
                run[s] = 1'b0;
                s++;
            end
            g++;
            for (int i = 0; i < 3; i++)
                ed[4*i +: 4] = 4'((n[i] / (4 + 2 * i)) % 10);
            if (s == 3) begin
                sc = '0;
                for (int i = 0; i < 3; i++)
                    if (ed[4*i +: 4] == 4'd7) sc = sc + 4'd1;
                jk = (ed[3:0] == ed[7:4]) && (ed[7:4] == ed[11:8]);
                push("rep_state", 16'd2);
                push("rep_digits", 16'(sc));
                push("rep_blank", 16'b110);
                push("rep_score", 16'(sc));
                push("rep_jackpot", 16'(jk));
                tick();
                pop(16'(state));
                pop(16'(digits[3:0]));
                pop(16'(blank));
                pop(16'(score));
                pop(16'(jackpot));
            end else begin
                push("run_state", 16'd1);
                push("run_digits", 16'(ed));
                tick();
                pop(16'(state));
                pop(16'(digits));
            end
        end
        btn = 1'b0;
    endtask

    task automatic back_to_idle(input logic [3:0] sc, input logic jk);
        btn = 1'b0;
        tick();
        btn = 1'b1;
        push_idle(sc, jk);
        tick();
        pop_all();
        btn = 1'b0;
    endtask

    logic [3:0] sc;
    logic       jk;

    initial begin
        rst = 1'b1;
        btn = 1'b1;
        tick();
        tick();
        push_idle(4'd0, 1'b0);
        pop_all();

        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            push_idle(4'd0, 1'b0);
            tick();
            pop_all();
        end

        enter_spin();
        play(41, 43, 45, sc, jk);
        back_to_idle(sc, jk);

        enter_spin();
        play(28, 42, 56, sc, jk);
        push("jackpot_score", 16'd3);
        pop(16'(sc));
        back_to_idle(4'd3, 1'b1);

        enter_spin();
        play(11, 42, 45, sc, jk);
        back_to_idle(4'd1, 1'b0);

        enter_spin();
        btn = 1'b0;
        tick();
        tick();
        btn = 1'b1;
        tick();
        btn = 1'b0;
        tick();
        tick();
        push("pre_rst_state", 16'd1);
        pop(16'(state));
        rst = 1'b1;
        #1;
        push_idle(4'd0, 1'b0);
        pop_all();
        tick();
        rst = 1'b0;
        tick();

        enter_spin();
        play(8, 20, 30, sc, jk);
        back_to_idle(4'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
